// File: rtl/glb_strm_f2g_packer.sv
// Ingress packer for one CGRA-to-GLB stream channel: gathers stream words into
// byte-strobed bank words starting at any 2-byte-aligned offset and pulses an interrupt on completion.
module glb_strm_f2g_packer #(
  parameter int CGRA_DATA_WIDTH     = 16,
  parameter int BANK_DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH          = 22,
  parameter int MAX_NUM_WORDS_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          cfg_start_addr,
  input  logic [MAX_NUM_WORDS_WIDTH-1:0] cfg_num_words,
  input  logic                           strm_start_pulse,
  input  logic [CGRA_DATA_WIDTH-1:0]     data_f2g,
  input  logic                           data_valid_f2g,
  output logic                           wr_en,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic [BANK_DATA_WIDTH-1:0]     wr_data,
  output logic [BANK_DATA_WIDTH/8-1:0]   wr_strb,
  output logic                           strm_f2g_interrupt,
  output logic                           busy,
  output logic [1:0]                     dbg_state_o
);

  localparam int NUM_LANES  = BANK_DATA_WIDTH / CGRA_DATA_WIDTH;
  localparam int LANE_W     = $clog2(NUM_LANES);
  localparam int LANE_BYTES = CGRA_DATA_WIDTH / 8;
  localparam int STRB_W     = BANK_DATA_WIDTH / 8;
  localparam int BANK_BYTES = BANK_DATA_WIDTH / 8;

  localparam logic [LANE_W-1:0]              LAST_LANE = LANE_W'(NUM_LANES - 1);
  localparam logic [ADDR_WIDTH-1:0]          ADDR_STEP = ADDR_WIDTH'(BANK_BYTES);
  localparam logic [ADDR_WIDTH-1:0]          ADDR_MASK = ~ADDR_WIDTH'(BANK_BYTES - 1);
  localparam logic [MAX_NUM_WORDS_WIDTH-1:0] ONE_WORD  = MAX_NUM_WORDS_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [MAX_NUM_WORDS_WIDTH-1:0] remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]          cur_addr_q, cur_addr_d;
  logic [LANE_W-1:0]              lane_q, lane_d;
  logic [BANK_DATA_WIDTH-1:0]     acc_data_q, acc_data_d;
  logic [STRB_W-1:0]              acc_strb_q, acc_strb_d;

  logic                           wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]          wr_addr_q, wr_addr_d;
  logic [BANK_DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [STRB_W-1:0]              wr_strb_q, wr_strb_d;
  logic                           irq_q, irq_d;
  logic                           busy_q, busy_d;

  logic [BANK_DATA_WIDTH-1:0]     merged_data;
  logic [STRB_W-1:0]              merged_strb;
  logic                           flush;

  // Accumulator with the incoming word dropped into the current lane.
  always_comb begin
    merged_data = acc_data_q;
    merged_strb = acc_strb_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (lane_q == LANE_W'(k)) begin
        merged_data[k*CGRA_DATA_WIDTH +: CGRA_DATA_WIDTH] = data_f2g;
        merged_strb[k*LANE_BYTES +: LANE_BYTES]           = '1;
      end
    end
  end

  assign flush = (lane_q == LAST_LANE) || (remaining_q == ONE_WORD);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cur_addr_d  = cur_addr_q;
    lane_d      = lane_q;
    acc_data_d  = acc_data_q;
    acc_strb_d  = acc_strb_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strb_d   = wr_strb_q;

    unique case (state_q)
      ST_IDLE: begin
        if (strm_start_pulse) begin
          if (cfg_num_words != '0) begin
            remaining_d = cfg_num_words;
            cur_addr_d  = cfg_start_addr & ADDR_MASK;
            lane_d      = cfg_start_addr[LANE_W:1];
            acc_data_d  = '0;
            acc_strb_d  = '0;
            state_d     = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        if (data_valid_f2g) begin
          remaining_d = remaining_q - ONE_WORD;
          if (flush) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = cur_addr_q;
            wr_data_d  = merged_data;
            wr_strb_d  = merged_strb;
            acc_data_d = '0;
            acc_strb_d = '0;
            cur_addr_d = cur_addr_q + ADDR_STEP;
            lane_d     = '0;
            if (remaining_q == ONE_WORD) begin
              state_d = ST_DONE;
            end
          end else begin
            acc_data_d = merged_data;
            acc_strb_d = merged_strb;
            lane_d     = lane_q + LANE_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Interrupt and busy are registered views of the state being entered.
    irq_d  = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      cur_addr_q  <= '0;
      lane_q      <= '0;
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cur_addr_q  <= cur_addr_d;
      lane_q      <= lane_d;
      acc_data_q  <= acc_data_d;
      acc_strb_q  <= acc_strb_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strb_q   <= wr_strb_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
    end
  end

  assign wr_en              = wr_en_q;
  assign wr_addr            = wr_addr_q;
  assign wr_data            = wr_data_q;
  assign wr_strb            = wr_strb_q;
  assign strm_f2g_interrupt = irq_q;
  assign busy               = busy_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_glb_strm_f2g_packer.sv
// Directed bench for glb_strm_f2g_packer: expected bank writes are queued per test
// and compared by a negedge monitor that also checks interrupt and busy timing.
module tb_glb_strm_f2g_packer;

  localparam int AW = 22;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int W  = AW + DW + SW;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] cfg_start_addr;
  logic [15:0]   cfg_num_words;
  logic          strm_start_pulse;
  logic [15:0]   data_f2g;
  logic          data_valid_f2g;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          irq;
  logic          busy;
  logic [1:0]    dbg_state;

  glb_strm_f2g_packer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_start_addr     (cfg_start_addr),
    .cfg_num_words      (cfg_num_words),
    .strm_start_pulse   (strm_start_pulse),
    .data_f2g           (data_f2g),
    .data_valid_f2g     (data_valid_f2g),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .wr_strb            (wr_strb),
    .strm_f2g_interrupt (irq),
    .busy               (busy),
    .dbg_state_o        (dbg_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;
  int wr_cnt  = 0;
  int irq_cnt = 0;
  int last_wr_cyc  = -1;
  int last_irq_cyc = -1;
  int last_vld_cyc = -1;
  int start_cyc    = -1;
  bit chk_busy     = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_busy) begin
        check("irq_width", irq, 1'b0);
        check("busy_drop", busy, 1'b0);
        chk_busy = 1'b0;
      end
      if (wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexp_wr", wr_en, 1'b0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e[W-1 -: AW]);
          check("wr_data", wr_data, e[SW +: DW]);
          check("wr_strb", wr_strb, e[SW-1:0]);
        end
      end
      if (irq) begin
        irq_cnt++;
        last_irq_cyc = cyc;
        check("busy_at_irq", busy, 1'b1);
        chk_busy = 1'b1;
      end
    end
  end

  // driver tasks: every task leaves inputs changing 1 time unit after a posedge
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [15:0] n);
    cfg_start_addr   = a;
    cfg_num_words    = n;
    strm_start_pulse = 1'b1;
    @(posedge clk);
    #1;
    start_cyc        = cyc;
    strm_start_pulse = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    data_f2g       = d;
    data_valid_f2g = 1'b1;
    @(posedge clk);
    #1;
    last_vld_cyc   = cyc;
    data_valid_f2g = 1'b0;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    exp_q.push_back({a, d, s});
  endtask

  int w0, i0;

  initial begin
    rst_n            = 1'b0;
    cfg_start_addr   = '0;
    cfg_num_words    = '0;
    strm_start_pulse = 1'b0;
    data_f2g         = '0;
    data_valid_f2g   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_strb", wr_strb, 0);
    check("rst_irq", irq, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    idle(2);

    // aligned transfer of 8 words
    w0 = wr_cnt; i0 = irq_cnt;
    push_wr(22'h000100, 64'h0004_0003_0002_0001, 8'hFF);
    push_wr(22'h000108, 64'h0008_0007_0006_0005, 8'hFF);
    start(22'h000100, 16'd8);
    check("t1_busy", busy, 1'b1);
    for (int i = 1; i <= 8; i++) send(16'(i));
    idle(4);
    check("t1_nwr", wr_cnt - w0, 2);
    check("t1_nirq", irq_cnt - i0, 1);
    check("t1_wr_lat", last_wr_cyc, last_vld_cyc);
    check("t1_irq_cyc", last_irq_cyc, last_wr_cyc);
    check("t1_q", exp_q.size(), 0);

    // unaligned partial transfer
    w0 = wr_cnt; i0 = irq_cnt;
    push_wr(22'h000100, 64'h000A_0000_0000_0000, 8'hC0);
    push_wr(22'h000108, 64'h0000_0000_000C_000B, 8'h0F);
    start(22'h000106, 16'd3);
    send(16'h000A); send(16'h000B); send(16'h000C);
    idle(4);
    check("t2_nwr", wr_cnt - w0, 2);
    check("t2_nirq", irq_cnt - i0, 1);
    check("t2_q", exp_q.size(), 0);

    // gapped valid pattern 1,0,0,1,1,0,1
    w0 = wr_cnt; i0 = irq_cnt;
    push_wr(22'h000200, 64'h0004_0003_0002_0001, 8'hFF);
    start(22'h000200, 16'd4);
    send(16'h0001); idle(2); send(16'h0002); send(16'h0003); idle(1); send(16'h0004);
    idle(4);
    check("t3_nwr", wr_cnt - w0, 1);
    check("t3_wr_lat", last_wr_cyc, last_vld_cyc);
    check("t3_nirq", irq_cnt - i0, 1);
    check("t3_q", exp_q.size(), 0);

    // zero-length start
    w0 = wr_cnt; i0 = irq_cnt;
    start(22'h000300, 16'd0);
    idle(4);
    check("t4_nwr", wr_cnt - w0, 0);
    check("t4_nirq", irq_cnt - i0, 1);
    check("t4_irq_cyc", last_irq_cyc, start_cyc);

    // idle traffic is dropped; a start during RUN is ignored
    w0 = wr_cnt; i0 = irq_cnt;
    send(16'hDEAD); send(16'hBEEF); send(16'h1234);
    idle(2);
    check("t5_idle_nwr", wr_cnt - w0, 0);
    check("t5_idle_busy", busy, 1'b0);
    push_wr(22'h000040, 64'h0004_0003_0002_0001, 8'hFF);
    start(22'h000040, 16'd4);
    send(16'h0001); send(16'h0002);
    start(22'h000800, 16'd1);
    check("t5_state_run", dbg_state, 2'd1);
    send(16'h0003); send(16'h0004);
    idle(4);
    check("t5_nwr", wr_cnt - w0, 1);
    check("t5_nirq", irq_cnt - i0, 1);
    check("t5_q", exp_q.size(), 0);

    // address wrap at the top of the GLB
    w0 = wr_cnt;
    push_wr(22'h3FFFF8, 64'h0013_0012_0011_0010, 8'hFF);
    push_wr(22'h000000, 64'h0017_0016_0015_0014, 8'hFF);
    start(22'h3FFFF8, 16'd8);
    for (int i = 0; i < 8; i++) send(16'(16'h0010 + i));
    idle(4);
    check("t6_nwr", wr_cnt - w0, 2);
    check("t6_q", exp_q.size(), 0);

    // reset in the middle of a transfer
    w0 = wr_cnt; i0 = irq_cnt;
    start(22'h000300, 16'd6);
    send(16'h0055); send(16'h0066);
    check("t7_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t7_busy", busy, 1'b0);
    check("t7_wr_en", wr_en, 1'b0);
    check("t7_wr_addr", wr_addr, 0);
    check("t7_wr_data", wr_data, 0);
    check("t7_wr_strb", wr_strb, 0);
    check("t7_irq", irq, 1'b0);
    check("t7_state", dbg_state, 2'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("t7_nwr", wr_cnt - w0, 0);
    check("t7_nirq", irq_cnt - i0, 0);
    push_wr(22'h000300, 64'h0014_0013_0012_0011, 8'hFF);
    start(22'h000300, 16'd4);
    send(16'h0011); send(16'h0012); send(16'h0013); send(16'h0014);
    idle(4);
    check("t7_post_nwr", wr_cnt - w0, 1);
    check("t7_post_nirq", irq_cnt - i0, 1);
    check("t7_post_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
